// File: rtl/phv_action_pairer.sv
// Pairs each PHV with the action word the match stage returns for it, strictly in order,
// and presents the pair to the stage crossbar through a registered valid/ready output stage.
module phv_action_pairer #(
  parameter int unsigned PHV_LEN = 2304,
  parameter int unsigned ACT_LEN = 64,
  parameter int unsigned NUM_ACT = 65,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned AW      = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [PHV_LEN-1:0]         phv_in,
  input  logic                       phv_in_valid,
  output logic                       phv_in_ready,
  input  logic [ACT_LEN*NUM_ACT-1:0] act_in,
  input  logic                       act_in_valid,
  output logic                       act_in_ready,
  output logic [PHV_LEN-1:0]         phv_out,
  output logic [ACT_LEN*NUM_ACT-1:0] act_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [AW:0]                phv_count,
  output logic                       err_overflow,
  output logic                       err_orphan
);

  localparam int unsigned ActW    = ACT_LEN * NUM_ACT;
  localparam logic [AW:0] CntFull = (AW+1)'(DEPTH);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e state_q, state_d;

  // Storage arrays carry no reset; only pointers and counts define FIFO contents.
  logic [PHV_LEN-1:0] phv_mem_q [DEPTH];
  logic [ActW-1:0]    act_mem_q [DEPTH];

  logic [AW-1:0] phv_wptr_q, phv_wptr_d, phv_rptr_q, phv_rptr_d;
  logic [AW-1:0] act_wptr_q, act_wptr_d, act_rptr_q, act_rptr_d;
  logic [AW:0]   phv_cnt_q, phv_cnt_d, act_cnt_q, act_cnt_d;

  logic [PHV_LEN-1:0] phv_out_q, phv_out_d;
  logic [ActW-1:0]    act_out_q, act_out_d;
  logic               ovf_q, ovf_d, orph_q, orph_d;

  logic phv_we, act_we, pop;

  assign phv_in_ready = (phv_cnt_q != CntFull);
  assign act_in_ready = (act_cnt_q != CntFull);

  assign phv_we = phv_in_valid & phv_in_ready;
  assign act_we = act_in_valid & act_in_ready;

  // Both heads leave together so the k-th PHV always meets the k-th action.
  assign pop = (phv_cnt_q != '0) && (act_cnt_q != '0) && ((state_q == StEmpty) || out_ready);

  // PHV FIFO bookkeeping
  always_comb begin
    phv_wptr_d = phv_wptr_q;
    phv_rptr_d = phv_rptr_q;
    phv_cnt_d  = phv_cnt_q;
    if (flush) begin
      phv_wptr_d = '0;
      phv_rptr_d = '0;
      phv_cnt_d  = '0;
    end else begin
      if (phv_we) phv_wptr_d = phv_wptr_q + 1'b1;
      if (pop)    phv_rptr_d = phv_rptr_q + 1'b1;
      phv_cnt_d = phv_cnt_q + (AW+1)'(phv_we) - (AW+1)'(pop);
    end
  end

  // Action FIFO bookkeeping
  always_comb begin
    act_wptr_d = act_wptr_q;
    act_rptr_d = act_rptr_q;
    act_cnt_d  = act_cnt_q;
    if (flush) begin
      act_wptr_d = '0;
      act_rptr_d = '0;
      act_cnt_d  = '0;
    end else begin
      if (act_we) act_wptr_d = act_wptr_q + 1'b1;
      if (pop)    act_rptr_d = act_rptr_q + 1'b1;
      act_cnt_d = act_cnt_q + (AW+1)'(act_we) - (AW+1)'(pop);
    end
  end

  // Sticky error flags; orphan is judged on next-state counts.
  always_comb begin
    ovf_d  = ovf_q | (phv_in_valid & ~phv_in_ready) | (act_in_valid & ~act_in_ready);
    orph_d = orph_q | (act_cnt_d > phv_cnt_d);
    if (flush) begin
      ovf_d  = 1'b0;
      orph_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (phv_we && !flush) phv_mem_q[phv_wptr_q] <= phv_in;
    if (act_we && !flush) act_mem_q[act_wptr_q] <= act_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phv_wptr_q <= '0;
      phv_rptr_q <= '0;
      phv_cnt_q  <= '0;
      act_wptr_q <= '0;
      act_rptr_q <= '0;
      act_cnt_q  <= '0;
      ovf_q      <= 1'b0;
      orph_q     <= 1'b0;
    end else begin
      phv_wptr_q <= phv_wptr_d;
      phv_rptr_q <= phv_rptr_d;
      phv_cnt_q  <= phv_cnt_d;
      act_wptr_q <= act_wptr_d;
      act_rptr_q <= act_rptr_d;
      act_cnt_q  <= act_cnt_d;
      ovf_q      <= ovf_d;
      orph_q     <= orph_d;
    end
  end

  // Output stage: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StEmpty;
      phv_out_q <= '0;
      act_out_q <= '0;
    end else begin
      state_q   <= state_d;
      phv_out_q <= phv_out_d;
      act_out_q <= act_out_d;
    end
  end

  // Output stage: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (pop)               state_d = StFull;
      StFull:  if (out_ready && !pop) state_d = StEmpty;
      default:                        state_d = StEmpty;
    endcase
    if (flush) state_d = StEmpty;
  end

  // Output stage: data load; held while the crossbar stalls
  always_comb begin
    phv_out_d = phv_out_q;
    act_out_d = act_out_q;
    if (flush) begin
      phv_out_d = '0;
      act_out_d = '0;
    end else if (pop) begin
      phv_out_d = phv_mem_q[phv_rptr_q];
      act_out_d = act_mem_q[act_rptr_q];
    end
  end

  assign out_valid    = (state_q == StFull);
  assign phv_out      = phv_out_q;
  assign act_out      = act_out_q;
  assign phv_count    = phv_cnt_q;
  assign err_overflow = ovf_q;
  assign err_orphan   = orph_q;

endmodule

// File: tb/tb_phv_action_pairer.sv
// Bench for phv_action_pairer: directed scenarios plus random traffic checked against a
// queue-based model of the pairing rules.
module tb_phv_action_pairer;

  localparam int unsigned PHV_LEN = 2304;
  localparam int unsigned ACT_LEN = 64;
  localparam int unsigned NUM_ACT = 65;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned AW      = 3;
  localparam int unsigned AL      = ACT_LEN * NUM_ACT;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic [PHV_LEN-1:0] phv_in = '0;
  logic              phv_in_valid = 1'b0;
  logic              phv_in_ready;
  logic [AL-1:0]     act_in = '0;
  logic              act_in_valid = 1'b0;
  logic              act_in_ready;
  logic [PHV_LEN-1:0] phv_out;
  logic [AL-1:0]     act_out;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [AW:0]       phv_count;
  logic              err_overflow;
  logic              err_orphan;

  int errors = 0;
  int checks = 0;

  // Model state
  logic [PHV_LEN-1:0] m_phv[$];
  logic [AL-1:0]      m_act[$];
  bit                 m_valid;
  logic [PHV_LEN-1:0] m_phv_out;
  logic [AL-1:0]      m_act_out;
  bit                 m_ovf, m_orph;

  phv_action_pairer #(
    .PHV_LEN(PHV_LEN), .ACT_LEN(ACT_LEN), .NUM_ACT(NUM_ACT), .DEPTH(DEPTH), .AW(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .phv_in(phv_in), .phv_in_valid(phv_in_valid), .phv_in_ready(phv_in_ready),
    .act_in(act_in), .act_in_valid(act_in_valid), .act_in_ready(act_in_ready),
    .phv_out(phv_out), .act_out(act_out), .out_valid(out_valid), .out_ready(out_ready),
    .phv_count(phv_count), .err_overflow(err_overflow), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  function automatic logic [PHV_LEN-1:0] rand_phv();
    logic [PHV_LEN-1:0] r;
    for (int i = 0; i < PHV_LEN / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [AL-1:0] rand_act();
    logic [AL-1:0] r;
    for (int i = 0; i < AL / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic model_clear();
    m_phv.delete();
    m_act.delete();
    m_valid   = 1'b0;
    m_phv_out = '0;
    m_act_out = '0;
    m_ovf     = 1'b0;
    m_orph    = 1'b0;
  endtask

  // Advance the model by one cycle using the current inputs, then clock the DUT.
  task automatic step();
    bit pr, ar, pop;
    if (!rst_n || flush) begin
      model_clear();
    end else begin
      pr  = (m_phv.size() != DEPTH);
      ar  = (m_act.size() != DEPTH);
      pop = (m_phv.size() > 0) && (m_act.size() > 0) && (!m_valid || out_ready);
      if ((phv_in_valid && !pr) || (act_in_valid && !ar)) m_ovf = 1'b1;
      if (pop) begin
        m_phv_out = m_phv.pop_front();
        m_act_out = m_act.pop_front();
        m_valid   = 1'b1;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
      if (phv_in_valid && pr) m_phv.push_back(phv_in);
      if (act_in_valid && ar) m_act.push_back(act_in);
      if (m_act.size() > m_phv.size()) m_orph = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    phv_in_valid = 1'b0;
    act_in_valid = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic do_flush();
    idle_inputs();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    out_ready = 1'b0;
    #3;
    checks++;
    if (out_valid !== 1'b0 || phv_count !== '0) begin
      errors++;
      $display("FAIL reset_out: out_valid=%0b phv_count=%0d, expected 0/0", out_valid, phv_count);
    end
    checks++;
    if (phv_in_ready !== 1'b1 || act_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: phv_in_ready=%0b act_in_ready=%0b, expected 1/1",
               phv_in_ready, act_in_ready);
    end
    checks++;
    if (phv_out !== '0 || act_out !== '0 || err_overflow !== 1'b0 || err_orphan !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: phv_out[31:0]=%h act_out[31:0]=%h ovf=%0b orph=%0b, expected 0",
               phv_out[31:0], act_out[31:0], err_overflow, err_orphan);
    end
    step();
    step();
    rst_n = 1'b1;
    model_clear();
    step();
  endtask

  task automatic test_latency();
    logic [PHV_LEN-1:0] aa;
    logic [AL-1:0]      one;
    aa  = {(PHV_LEN/4){4'hA}};
    one = AL'(1);
    do_flush();
    out_ready    = 1'b1;
    phv_in       = aa;
    act_in       = one;
    phv_in_valid = 1'b1;
    act_in_valid = 1'b1;
    step();
    idle_inputs();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_cycle1: out_valid=%0b, expected 0", out_valid);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || phv_out !== aa || act_out !== one) begin
      errors++;
      $display("FAIL latency_cycle2: out_valid=%0b phv[31:0]=%h act[31:0]=%h, expected 1/aaaaaaaa/1",
               out_valid, phv_out[31:0], act_out[31:0]);
    end
    checks++;
    if (phv_count !== '0) begin
      errors++;
      $display("FAIL latency_count: phv_count=%0d, expected 0", phv_count);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_drain: out_valid=%0b, expected 0", out_valid);
    end
  endtask

  task automatic test_delayed_actions();
    int pulses[$];
    do_flush();
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 18; cyc++) begin
      phv_in_valid = (cyc < 3);
      phv_in       = rand_phv();
      act_in_valid = (cyc == 5) || (cyc == 8) || (cyc == 12);
      act_in       = rand_act();
      step();
      if (out_valid === 1'b1) pulses.push_back(cyc + 1);
      checks++;
      if (out_valid !== m_valid || (m_valid && (phv_out !== m_phv_out || act_out !== m_act_out)))
      begin
        errors++;
        $display("FAIL delayed_pair cyc%0d: valid=%0b phv[31:0]=%h act[31:0]=%h, expected %0b/%h/%h",
                 cyc + 1, out_valid, phv_out[31:0], act_out[31:0], m_valid, m_phv_out[31:0],
                 m_act_out[31:0]);
      end
    end
    idle_inputs();
    checks++;
    if (pulses.size() != 3 || pulses[0] != 7 || pulses[1] != 10 || pulses[2] != 14) begin
      errors++;
      $display("FAIL delayed_timing: %0d pulses, first at %0d, expected 3 pulses at 7,10,14",
               pulses.size(), (pulses.size() > 0) ? pulses[0] : -1);
    end
  endtask

  task automatic test_backpressure();
    logic [PHV_LEN-1:0] first_phv;
    logic [AL-1:0]      first_act;
    do_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      phv_in       = rand_phv();
      act_in       = rand_act();
      if (i == 0) begin
        first_phv = phv_in;
        first_act = act_in;
      end
      phv_in_valid = 1'b1;
      act_in_valid = 1'b1;
      step();
    end
    idle_inputs();
    step();
    checks++;
    if (phv_count !== 4'd7 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_count: phv_count=%0d out_valid=%0b, expected 7/1", phv_count, out_valid);
    end
    checks++;
    if (phv_out !== first_phv || act_out !== first_act) begin
      errors++;
      $display("FAIL bp_hold: phv[31:0]=%h act[31:0]=%h, expected %h/%h",
               phv_out[31:0], act_out[31:0], first_phv[31:0], first_act[31:0]);
    end
    phv_in       = rand_phv();
    phv_in_valid = 1'b1;
    step();
    checks++;
    if (phv_count !== 4'd8 || phv_in_ready !== 1'b0 || act_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ninth: phv_count=%0d phv_in_ready=%0b act_in_ready=%0b, expected 8/0/1",
               phv_count, phv_in_ready, act_in_ready);
    end
    checks++;
    if (err_overflow !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_ovf: err_overflow=%0b, expected 0", err_overflow);
    end
    phv_in = rand_phv();
    step();
    idle_inputs();
    checks++;
    if (err_overflow !== 1'b1 || phv_count !== 4'd8) begin
      errors++;
      $display("FAIL bp_overflow: err_overflow=%0b phv_count=%0d, expected 1/8",
               err_overflow, phv_count);
    end
    checks++;
    if (out_valid !== 1'b1 || phv_out !== first_phv || act_out !== first_act) begin
      errors++;
      $display("FAIL bp_hold_after: valid=%0b phv[31:0]=%h, expected 1/%h",
               out_valid, phv_out[31:0], first_phv[31:0]);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if (out_valid !== m_valid || phv_count !== AW'(m_phv.size()) + 4'd0 ||
          (m_valid && (phv_out !== m_phv_out || act_out !== m_act_out))) begin
        errors++;
        $display("FAIL bp_drain%0d: valid=%0b cnt=%0d phv[31:0]=%h, expected %0b/%0d/%h",
                 i, out_valid, phv_count, phv_out[31:0], m_valid, m_phv.size(), m_phv_out[31:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int run, best;
    do_flush();
    out_ready = 1'b1;
    run  = 0;
    best = 0;
    for (int i = 0; i < 24; i++) begin
      phv_in_valid = (i < 20);
      act_in_valid = (i < 20);
      phv_in       = rand_phv();
      act_in       = rand_act();
      step();
      if (out_valid === 1'b1) run++;
      else run = 0;
      if (run > best) best = run;
      checks++;
      if (out_valid !== m_valid || (m_valid && (phv_out !== m_phv_out || act_out !== m_act_out)))
      begin
        errors++;
        $display("FAIL b2b_pair%0d: valid=%0b phv[31:0]=%h act[31:0]=%h, expected %0b/%h/%h",
                 i, out_valid, phv_out[31:0], act_out[31:0], m_valid, m_phv_out[31:0],
                 m_act_out[31:0]);
      end
    end
    idle_inputs();
    checks++;
    if (best != 20) begin
      errors++;
      $display("FAIL b2b_run: %0d consecutive out_valid cycles, expected 20", best);
    end
  endtask

  task automatic test_orphan();
    do_flush();
    out_ready    = 1'b1;
    act_in       = rand_act();
    act_in_valid = 1'b1;
    step();
    idle_inputs();
    checks++;
    if (err_orphan !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL orphan_set: err_orphan=%0b out_valid=%0b, expected 1/0", err_orphan, out_valid);
    end
    // Flush must win over a same-cycle PHV write.
    flush        = 1'b1;
    phv_in       = rand_phv();
    phv_in_valid = 1'b1;
    step();
    idle_inputs();
    checks++;
    if (err_orphan !== 1'b0 || phv_count !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL orphan_flush: err_orphan=%0b phv_count=%0d out_valid=%0b, expected 0/0/0",
               err_orphan, phv_count, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      phv_in       = rand_phv();
      act_in       = rand_act();
      phv_in_valid = 1'b1;
      act_in_valid = 1'b1;
      step();
    end
    idle_inputs();
    step();
    checks++;
    if (out_valid !== 1'b1 || phv_count !== 4'd4) begin
      errors++;
      $display("FAIL rstmid_pre: out_valid=%0b phv_count=%0d, expected 1/4", out_valid, phv_count);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || phv_count !== '0 || phv_out !== '0 || act_out !== '0 ||
        phv_in_ready !== 1'b1 || act_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_async: valid=%0b cnt=%0d phv[31:0]=%h rdy=%0b/%0b, expected 0/0/0/1/1",
               out_valid, phv_count, phv_out[31:0], phv_in_ready, act_in_ready);
    end
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_quiet%0d: out_valid=%0b, expected 0", i, out_valid);
      end
    end
    phv_in       = rand_phv();
    act_in       = rand_act();
    phv_in_valid = 1'b1;
    act_in_valid = 1'b1;
    step();
    idle_inputs();
    step();
    checks++;
    if (out_valid !== 1'b1 || phv_out !== m_phv_out || act_out !== m_act_out) begin
      errors++;
      $display("FAIL rstmid_new: valid=%0b phv[31:0]=%h, expected 1/%h",
               out_valid, phv_out[31:0], m_phv_out[31:0]);
    end
  endtask

  task automatic test_random();
    do_flush();
    for (int i = 0; i < 400; i++) begin
      flush        = ($urandom_range(0, 79) == 0);
      phv_in_valid = ($urandom_range(0, 2) != 0);
      act_in_valid = ($urandom_range(0, 2) != 0);
      out_ready    = ($urandom_range(0, 3) != 0);
      phv_in       = rand_phv();
      act_in       = rand_act();
      step();
      checks++;
      if (out_valid !== m_valid || (m_valid && (phv_out !== m_phv_out || act_out !== m_act_out)))
      begin
        errors++;
        $display("FAIL rnd_pair%0d: valid=%0b phv[31:0]=%h act[31:0]=%h, expected %0b/%h/%h",
                 i, out_valid, phv_out[31:0], act_out[31:0], m_valid, m_phv_out[31:0],
                 m_act_out[31:0]);
      end
      checks++;
      if (phv_count !== 4'(m_phv.size()) || phv_in_ready !== (m_phv.size() != DEPTH) ||
          act_in_ready !== (m_act.size() != DEPTH)) begin
        errors++;
        $display("FAIL rnd_fifo%0d: cnt=%0d rdy=%0b/%0b, expected %0d/%0b/%0b", i, phv_count,
                 phv_in_ready, act_in_ready, m_phv.size(), m_phv.size() != DEPTH,
                 m_act.size() != DEPTH);
      end
      checks++;
      if (err_overflow !== m_ovf || err_orphan !== m_orph) begin
        errors++;
        $display("FAIL rnd_err%0d: ovf=%0b orph=%0b, expected %0b/%0b", i, err_overflow,
                 err_orphan, m_ovf, m_orph);
      end
    end
    idle_inputs();
  endtask

  initial begin
    model_clear();
    test_reset();
    test_latency();
    test_delayed_actions();
    test_backpressure();
    test_back_to_back();
    test_orphan();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
